nand_stim_seq: RTL and testbench
================================

# nand_stim_seq

Self-checking stimulus sequencer that sits directly upstream of the two-input `nand_gate` and also consumes its output. On `start` it drives `a`/`b` through the four input vectors 00, 01, 10, 11 and holds each vector for a programmable number of cycles. At the end of each hold window it samples `y` and compares it against a parameterised truth table. It counts mismatches and reports a pass/fail verdict, which replaces the hand-written `#10` stimulus sequences in the gate benches.

## Interface
- `HOLD_CYCLES`, 10: cycles each vector is held; minimum 1.
- `TRUTH`, 4'b0111: expected `y` indexed by `{a,b}`. Bit 0 is the expected output for 00; the default is NAND.
- `ERR_W`, 8: width of the error counter.

- `clk` in 1: the single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begins a run when sampled high in IDLE.
- `y` in 1: output of the device under test.
- `a` out 1: DUT input a.
- `b` out 1: DUT input b.
- `busy` out 1: high while a run is in progress.
- `done` out 1: one-cycle pulse at the end of a pass.
- `pass` out 1: verdict of the last completed pass; 1 means zero mismatches.
- `mismatch` out 1: one-cycle pulse when a sampled `y` differs from `TRUTH`.
- `fail_idx` out 2: `{a,b}` of the most recent mismatch.
- `err_cnt` out ERR_W: saturating mismatch count.

## Operation
- States: IDLE and HOLD. Internal registers: `vec[1:0]`, the hold counter `cnt` of width clog2(HOLD_CYCLES) (minimum 1), and the per-pass error flag `perr`.
- Outputs are driven as `a = vec[1]`, `b = vec[0]`, both registered.
- IDLE with `start`=1:
  - Set `vec`←0, `cnt`←0, `err_cnt`←0, `perr`←0, `busy`←1.
  - Go to HOLD.
- IDLE with `start`=0: hold all outputs.
- HOLD with `cnt` < HOLD_CYCLES-1: `cnt`←`cnt`+1.
- HOLD with `cnt` == HOLD_CYCLES-1, the sample cycle:
  - Compare `y` against `TRUTH[vec]`.
  - On mismatch: pulse `mismatch`, set `fail_idx`←`vec`, set `perr`←1, and increment `err_cnt`. `err_cnt` saturates at 2^ERR_W-1.
  - If `vec` != 3: `vec`←`vec`+1 and `cnt`←0.
  - If `vec` == 3: end of pass (see below).
- End of pass: pulse `done`, set `pass`←!(`perr` or the current mismatch), clear `busy`, go to IDLE.
- `start` is ignored while `busy`=1.
- `y` is used only in the sample cycle. The DUT must be combinational or settle within HOLD_CYCLES-1 cycles.

## Timing
- Reset values: `a`=0, `b`=0, `busy`=0, `done`=0, `pass`=0, `mismatch`=0, `fail_idx`=0, `err_cnt`=0, state IDLE. Reset mid-run aborts immediately to these values, with no `done` pulse.
- `start` sampled high at edge N:
  - `busy`=1 and `{a,b}`=00 after edge N.
  - Vector k is driven from edge N+k·HOLD_CYCLES to edge N+(k+1)·HOLD_CYCLES.
- `y` is sampled in the last cycle of each window. `mismatch`, `fail_idx` and `err_cnt` update on the window's closing edge.
- `done` is high for the single cycle after edge N+4·HOLD_CYCLES. In that same cycle `busy`=0 and `pass` is valid.
- `{a,b}` holds 11 after the pass until the next `start`.
- `start` high in the cycle `done` is high is accepted: the next pass begins after that edge.
- `pass` and `fail_idx` hold their values until the next `done` or reset.

## Configuration
- `NAND_STIM_SEQ_LOOP_EN`:
  - Defined: at the end of a pass, `vec` wraps to 0 and the block stays in HOLD with `busy`=1, looping until `rst`. `done` pulses and `pass` updates at the end of every pass. `perr` clears at the start of each pass. `err_cnt` accumulates across passes (saturating).
  - Undefined: single pass, then return to IDLE as specified above.

## Test plan
- NAND DUT attached, default parameters, `start` pulse: `{a,b}` sequence 00/01/10/11, each held 10 cycles; `done` 40 cycles after the start edge; `pass`=1, `err_cnt`=0, `mismatch` never high.
- `y` tied to 1: exactly one `mismatch`, in vector 3's window; `fail_idx`=3, `err_cnt`=1, `pass`=0.
- `y` tied to 0, `TRUTH`=4'b0111: three mismatches, `fail_idx`=2 at done, `err_cnt`=3; with `ERR_W`=1, `err_cnt` saturates at 1.
- `HOLD_CYCLES`=1: vector changes every cycle and `done` comes 4 cycles after start; `start` re-pulsed while busy has no effect.
- `rst` asserted during vector 2: all outputs return to reset values on the next edge with no `done`; a new `start` then completes normally.
- With `NAND_STIM_SEQ_LOOP_EN`, NAND DUT: `done` every 40 cycles, vectors wrap 11→00, `busy` stays 1, `pass`=1 each pass.

Source files
------------

// File: rtl/nand_stim_seq_if.sv
// Handshake and DUT-facing signals of the nand_stim_seq stimulus sequencer.
// master: the controller that starts runs and returns the gate output y.
// slave : the sequencer itself.
interface nand_stim_seq_if #(
   parameter int unsigned ERR_W = 8
);
   logic             start;
   logic             y;
   logic             a;
   logic             b;
   logic             busy;
   logic             done;
   logic             pass;
   logic             mismatch;
   logic [1:0]       fail_idx;
   logic [ERR_W-1:0] err_cnt;

   modport master (
      output start, y,
      input  a, b, busy, done, pass, mismatch, fail_idx, err_cnt
   );

   modport slave (
      input  start, y,
      output a, b, busy, done, pass, mismatch, fail_idx, err_cnt
   );
endinterface

// File: rtl/nand_stim_seq.sv
// Self-checking stimulus sequencer for a two-input gate: walks {a,b} through
// 00,01,10,11, holds each for HOLD_CYCLES, samples y at the end of each window
// against TRUTH and reports mismatches and a pass verdict.
// Optional feature macro: NAND_STIM_SEQ_LOOP_EN (continuous looping passes).
module nand_stim_seq #(
   parameter int unsigned HOLD_CYCLES = 10,
   parameter logic [3:0]  TRUTH       = 4'b0111,
   parameter int unsigned ERR_W       = 8
) (
   input  logic           clk,
   input  logic           rst,
   nand_stim_seq_if.slave bus
);

   localparam int unsigned      CNT_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [ERR_W-1:0] ERR_MAX  = '1;

   typedef enum logic {ST_IDLE, ST_HOLD} state_t;

   state_t           state_q,    state_d;
   logic [1:0]       vec_q,      vec_d;
   logic [CNT_W-1:0] cnt_q,      cnt_d;
   logic             perr_q,     perr_d;
   logic             busy_q,     busy_d;
   logic             done_q,     done_d;
   logic             pass_q,     pass_d;
   logic             mismatch_q, mismatch_d;
   logic [1:0]       fail_idx_q, fail_idx_d;
   logic [ERR_W-1:0] err_cnt_q,  err_cnt_d;

   logic             miss_c;

   // State and output registers, synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         vec_q      <= 2'd0;
         cnt_q      <= '0;
         perr_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         mismatch_q <= 1'b0;
         fail_idx_q <= 2'd0;
         err_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         vec_q      <= vec_d;
         cnt_q      <= cnt_d;
         perr_q     <= perr_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
         mismatch_q <= mismatch_d;
         fail_idx_q <= fail_idx_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   // y is only meaningful in the sample cycle; compare it against the table.
   assign miss_c = (bus.y != TRUTH[vec_q]);

   // Next-state and output logic; pulses default low, everything else holds.
   always_comb begin
      state_d    = state_q;
      vec_d      = vec_q;
      cnt_d      = cnt_q;
      perr_d     = perr_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      pass_d     = pass_q;
      mismatch_d = 1'b0;
      fail_idx_d = fail_idx_q;
      err_cnt_d  = err_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               vec_d     = 2'd0;
               cnt_d     = '0;
               err_cnt_d = '0;
               perr_d    = 1'b0;
               busy_d    = 1'b1;
               state_d   = ST_HOLD;
            end
         end

         ST_HOLD: begin
            if (cnt_q != CNT_LAST) begin
               cnt_d = cnt_q + CNT_W'(1);
            end else begin
               if (miss_c) begin
                  mismatch_d = 1'b1;
                  fail_idx_d = vec_q;
                  perr_d     = 1'b1;
                  if (err_cnt_q != ERR_MAX) begin
                     err_cnt_d = err_cnt_q + ERR_W'(1);
                  end
               end
               cnt_d = '0;
               if (vec_q != 2'd3) begin
                  vec_d = vec_q + 2'd1;
               end else begin
                  done_d = 1'b1;
                  pass_d = !(perr_q || miss_c);
`ifdef NAND_STIM_SEQ_LOOP_EN
                  // Wrap straight into the next pass; error count keeps accumulating.
                  vec_d  = 2'd0;
                  perr_d = 1'b0;
`else
                  busy_d  = 1'b0;
                  state_d = ST_IDLE;
`endif
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.a        = vec_q[1];
   assign bus.b        = vec_q[0];
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.pass     = pass_q;
   assign bus.mismatch = mismatch_q;
   assign bus.fail_idx = fail_idx_q;
   assign bus.err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_nand_stim_seq.sv
// Directed bench for nand_stim_seq: default instance (HOLD_CYCLES=10, ERR_W=8)
// and a fast instance (HOLD_CYCLES=1, ERR_W=1), y driven by a NAND or a tie.
`timescale 1ns/1ps
module tb_nand_stim_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start0 = 1'b0;
   logic start1 = 1'b0;
   int   ymode = 0;   // 0: NAND gate, 1: y tied 1, 2: y tied 0
   int   sel   = 0;   // which instance is observed / started

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   nand_stim_seq_if #(.ERR_W(8)) bus0 ();
   nand_stim_seq_if #(.ERR_W(1)) bus1 ();

   assign bus0.start = start0;
   assign bus1.start = start1;
   assign bus0.y = (ymode == 0) ? ~(bus0.a & bus0.b) : (ymode == 1);
   assign bus1.y = (ymode == 0) ? ~(bus1.a & bus1.b) : (ymode == 1);

   nand_stim_seq #(.HOLD_CYCLES(10), .TRUTH(4'b0111), .ERR_W(8)) u_dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   nand_stim_seq #(.HOLD_CYCLES(1), .TRUTH(4'b0111), .ERR_W(1)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   // Observation mux over the selected instance.
   logic [1:0] o_ab;
   logic       o_busy, o_done, o_pass, o_mm;
   logic [1:0] o_fidx;
   logic [7:0] o_err;
   always_comb begin
      o_ab   = (sel == 0) ? {bus0.a, bus0.b} : {bus1.a, bus1.b};
      o_busy = (sel == 0) ? bus0.busy     : bus1.busy;
      o_done = (sel == 0) ? bus0.done     : bus1.done;
      o_pass = (sel == 0) ? bus0.pass     : bus1.pass;
      o_mm   = (sel == 0) ? bus0.mismatch : bus1.mismatch;
      o_fidx = (sel == 0) ? bus0.fail_idx : bus1.fail_idx;
      o_err  = (sel == 0) ? bus0.err_cnt  : 8'(bus1.err_cnt);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic set_start(input logic v);
      if (sel == 0) start0 = v;
      else          start1 = v;
   endtask

   // Start a pass and check every cycle up to and including the done cycle.
   // mmask bit k = vector k is expected to mismatch.
   task automatic run_pass(input int h, input logic [3:0] mmask, input logic [1:0] exp_fidx,
                           input int exp_err, input logic exp_pass, input bit repulse);
      logic exp_mm;
      @(negedge clk);
      set_start(1'b1);
      @(posedge clk);
      #1 set_start(1'b0);
      for (int i = 0; i < 4 * h; i++) begin
         @(negedge clk);
         if (repulse && i == 1) set_start(1'b1);
         if (repulse && i == 2) set_start(1'b0);
         exp_mm = (i > 0 && (i % h) == 0) ? mmask[i / h - 1] : 1'b0;
         chk("run_ab",   32'(o_ab),   32'(i / h));
         chk("run_busy", 32'(o_busy), 32'd1);
         chk("run_done", 32'(o_done), 32'd0);
         chk("run_mm",   32'(o_mm),   32'(exp_mm));
      end
      set_start(1'b0);
      @(negedge clk);
      chk("end_done", 32'(o_done), 32'd1);
      chk("end_busy", 32'(o_busy), 32'd0);
      chk("end_pass", 32'(o_pass), 32'(exp_pass));
      chk("end_err",  32'(o_err),  32'(exp_err));
      chk("end_fidx", 32'(o_fidx), 32'(exp_fidx));
      chk("end_mm",   32'(o_mm),   32'(mmask[3]));
      chk("end_ab",   32'(o_ab),   32'd3);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ab"},   32'(o_ab),   32'd0);
      chk({tag, "_busy"}, 32'(o_busy), 32'd0);
      chk({tag, "_done"}, 32'(o_done), 32'd0);
      chk({tag, "_pass"}, 32'(o_pass), 32'd0);
      chk({tag, "_mm"},   32'(o_mm),   32'd0);
      chk({tag, "_fidx"}, 32'(o_fidx), 32'd0);
      chk({tag, "_err"},  32'(o_err),  32'd0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      sel = 0;
      chk_reset_vals("rst0");
      sel = 1;
      chk_reset_vals("rst1");

      // NAND attached: clean pass.
      sel = 0; ymode = 0;
      run_pass(10, 4'b0000, 2'd0, 0, 1'b1, 1'b0);

      // y tied 1: only vector 3 fails.
      ymode = 1;
      run_pass(10, 4'b1000, 2'd3, 1, 1'b0, 1'b0);

      // y tied 0: vectors 0..2 fail, last failure index is 2.
      ymode = 2;
      run_pass(10, 4'b0111, 2'd2, 3, 1'b0, 1'b0);

      // Fast instance: one cycle per vector, 1-bit counter saturates, start re-pulsed while busy.
      sel = 1; ymode = 2;
      run_pass(1, 4'b0111, 2'd2, 1, 1'b0, 1'b1);
      @(negedge clk);
      chk("fast_idle_busy", 32'(o_busy), 32'd0);
      chk("fast_idle_done", 32'(o_done), 32'd0);

      // Reset during vector 2 aborts with no done.
      sel = 0; ymode = 0;
      @(negedge clk);
      start0 = 1'b1;
      @(posedge clk);
      #1 start0 = 1'b0;
      for (int i = 0; i < 26; i++) @(negedge clk);
      chk("pre_rst_ab", 32'(o_ab), 32'd2);
      rst = 1'b1;
      @(negedge clk);
      chk_reset_vals("midrst");
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("post_rst_done", 32'(o_done), 32'd0);
      end

      // Fresh run after reset completes normally.
      run_pass(10, 4'b0000, 2'd0, 0, 1'b1, 1'b0);

      // start in the done cycle is accepted immediately.
      start0 = 1'b1;
      @(posedge clk);
      #1 start0 = 1'b0;
      @(negedge clk);
      chk("b2b_busy", 32'(o_busy), 32'd1);
      chk("b2b_ab",   32'(o_ab),   32'd0);
      chk("b2b_done", 32'(o_done), 32'd0);
      chk("b2b_pass", 32'(o_pass), 32'd1);
      repeat (39) @(negedge clk);
      chk("b2b_ab3",   32'(o_ab),   32'd3);
      chk("b2b_nodone", 32'(o_done), 32'd0);
      @(negedge clk);
      chk("b2b_done2", 32'(o_done), 32'd1);
      chk("b2b_pass2", 32'(o_pass), 32'd1);
      chk("b2b_err2",  32'(o_err),  32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
